// File: rtl/vga_tile_timing_pkg.sv
// vga_tile_timing_pkg: shared 640x480 timing constants and tile-grid geometry
// used by the timing generator and the map/sprite renderer.
package vga_tile_timing_pkg;
    localparam int VGA_H_SYNC    = 92;
    localparam int VGA_H_BACK    = 50;
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 18;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_H_LINE    = VGA_H_SYNC + VGA_H_BACK + VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_V_FRAME   = VGA_V_SYNC + VGA_V_BACK + VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int TILE_SHIFT    = 5;
    localparam logic [9:0] TILE_MASK = 10'((1 << TILE_SHIFT) - 1);
    localparam int GRID_W        = VGA_H_DISPLAY >> TILE_SHIFT;
    localparam int GRID_H        = VGA_V_DISPLAY >> TILE_SHIFT;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH x WIDTH shift register with a synchronous reset value;
// DEPTH=0 degenerates to a wire.
module sync_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];
            always_ff @(posedge i_Clk) begin
                if (i_Reset) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= rst_val;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end
            assign q = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_tile_timing.sv
// vga_tile_timing: VGA sync plus tile-grid coordinates for the renderer.
// Define VGA_TIMING_GAME_TICK_EN to build the frame counter and game-tick divider.
module vga_tile_timing
    import vga_tile_timing_pkg::*;
#(
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int H_DISPLAY  = VGA_H_DISPLAY,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int V_DISPLAY  = VGA_V_DISPLAY,
    parameter int V_FRONT    = VGA_V_FRONT,
`ifdef VGA_TIMING_GAME_TICK_EN
    parameter int TICK_DIV   = 4,
`endif
    parameter int SYNC_DELAY = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    output logic       o_VGA_HSync,
    output logic       o_VGA_VSync,
    output logic       o_Active_Dly,
    output logic       o_Active,
    output logic [4:0] o_Cell_X,
    output logic [3:0] o_Cell_Y,
    output logic [4:0] o_Pix_X,
    output logic [4:0] o_Pix_Y,
    output logic       o_Line_Start,
    output logic       o_Frame_Start,
    output logic       o_Game_Tick,
    output logic [7:0] o_Frame_Count
);
    localparam int H_LINE  = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
    localparam int V_FRAME = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;
    localparam int H_ACT   = H_SYNC + H_BACK;
    localparam int V_ACT   = V_SYNC + V_BACK;

    logic [9:0] h, v, x, y;
    logic       h_last, v_last, act, frame_start, hs0, vs0;

    assign h_last      = h == 10'(H_LINE - 1);
    assign v_last      = v == 10'(V_FRAME - 1);
    assign x           = h - 10'(H_ACT);
    assign y           = v - 10'(V_ACT);
    assign act         = h >= 10'(H_ACT) && h < 10'(H_ACT + H_DISPLAY) &&
                         v >= 10'(V_ACT) && v < 10'(V_ACT + V_DISPLAY);
    assign frame_start = h == '0 && v == '0;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_last ? '0 : h + 10'd1;
            if (h_last) v <= v_last ? '0 : v + 10'd1;
        end
    end

    // Stage 0: everything the renderer addresses with is registered from the counters.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hs0           <= 1'b1;
            vs0           <= 1'b1;
            o_Active      <= 1'b0;
            o_Cell_X      <= '0;
            o_Cell_Y      <= '0;
            o_Pix_X       <= '0;
            o_Pix_Y       <= '0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            hs0           <= h >= 10'(H_SYNC);
            vs0           <= v >= 10'(V_SYNC);
            o_Active      <= act;
            o_Cell_X      <= act ? 5'(x >> TILE_SHIFT) : '0;
            o_Cell_Y      <= act ? 4'(y >> TILE_SHIFT) : '0;
            o_Pix_X       <= act ? 5'(x & TILE_MASK) : '0;
            o_Pix_Y       <= act ? 5'(y & TILE_MASK) : '0;
            o_Line_Start  <= act && h == 10'(H_ACT);
            o_Frame_Start <= frame_start;
        end
    end

    // Sync idles high and active idles low while the pipe refills after reset.
    sync_delay_line #(.DEPTH(SYNC_DELAY), .WIDTH(3)) u_dly (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .rst_val (3'b110),
        .d       ({hs0, vs0, o_Active}),
        .q       ({o_VGA_HSync, o_VGA_VSync, o_Active_Dly})
    );

`ifdef VGA_TIMING_GAME_TICK_EN
    logic [7:0] tick_div;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            tick_div      <= '0;
            o_Frame_Count <= '0;
            o_Game_Tick   <= 1'b0;
        end else begin
            o_Game_Tick <= frame_start && tick_div == 8'(TICK_DIV - 1);
            if (frame_start) begin
                o_Frame_Count <= o_Frame_Count + 8'd1;
                tick_div      <= tick_div == 8'(TICK_DIV - 1) ? '0 : tick_div + 8'd1;
            end
        end
    end
`else
    assign o_Frame_Count = '0;
    assign o_Game_Tick   = o_Frame_Start;
`endif
endmodule
